// File: rtl/int_seq.sv
// int_seq: interrupt/reset entry sequencer (RESET/NMI/IRQ/BRK push + vector fetch), ports CLK,RES,SYNC,BRK_REQ,NMI_N,IRQ_N,I_FLAG in; BUSY,DONE,SRC,WR,DB_OUT_SRC,AB_SEL,VEC_LO,S_DEC,PCL_LOAD,PCH_LOAD,P_SET_I,P_BREAK out
module int_seq #(
  parameter logic P_S_DEC_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       SYNC,
  input  logic       BRK_REQ,
  input  logic       NMI_N,
  input  logic       IRQ_N,
  input  logic       I_FLAG,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] SRC,
  output logic       WR,
  output logic [2:0] DB_OUT_SRC,
  output logic [1:0] AB_SEL,
  output logic [7:0] VEC_LO,
  output logic       S_DEC,
  output logic       PCL_LOAD,
  output logic       PCH_LOAD,
  output logic       P_SET_I,
  output logic       P_BREAK
);
  localparam logic [2:0] IDLE = 3'd0, RSTW = 3'd1, T1 = 3'd2, T2 = 3'd3,
                         T3 = 3'd4, T4 = 3'd5, T5 = 3'd6, T6 = 3'd7;
  logic [2:0] state;
  logic [1:0] src;
  logic       nmi_q, nmi_pend, brk_flag;
  logic       nmi_now, irq_ok, arb, hijack, commit, act, stk;
  logic [7:0] vec;
  assign nmi_now = nmi_pend | (nmi_q & ~NMI_N);
  assign irq_ok  = ~IRQ_N & ~I_FLAG;
  assign arb     = (state == IDLE) & SYNC & (nmi_now | BRK_REQ | irq_ok);
  assign hijack  = (state == T4) & (src == 2'd3) & nmi_now;
  assign commit  = (arb & nmi_now) | hijack;
  always_ff @(posedge CLK) begin
    if (RES) begin
      state    <= RSTW;
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
      brk_flag <= 1'b0;
      src      <= 2'd0;
    end else begin
      nmi_q    <= NMI_N;
      nmi_pend <= commit ? 1'b0 : nmi_now;
      case (state)
        IDLE: if (arb) begin
          state    <= T1;
          src      <= nmi_now ? 2'd2 : 2'd3;
          brk_flag <= ~nmi_now & BRK_REQ;
        end
        RSTW: begin
          state    <= T1;
          src      <= 2'd1;
          brk_flag <= 1'b0;
        end
        T4: begin
          state <= T5;
          if (hijack) src <= 2'd2;
        end
        T6: begin
          state <= IDLE;
          src   <= 2'd0;
        end
        default: state <= state + 3'd1;
      endcase
    end
  end
  // RES masks everything combinationally so outputs are quiet before the reset edge lands
  assign act        = ~RES;
  assign stk        = act & (state == T2 | state == T3 | state == T4);
  assign vec        = src == 2'd2 ? 8'hFA : src == 2'd1 ? 8'hFC : 8'hFE;
  assign BUSY       = RES | (state != IDLE);
  assign DONE       = act & (state == T6);
  assign SRC        = act ? src : 2'd0;
  assign WR         = stk & (src != 2'd1);
  assign DB_OUT_SRC = !stk ? 3'd0 : state == T2 ? 3'd6 : state == T3 ? 3'd5 : 3'd4;
  assign AB_SEL     = stk ? 2'd1 : act & (state == T5 | state == T6) ? 2'd2 : 2'd0;
  assign VEC_LO     = act & (state == T5) ? vec : act & (state == T6) ? (vec | 8'h01) : 8'h00;
  assign S_DEC      = stk & P_S_DEC_EN;
  assign PCL_LOAD   = act & (state == T5);
  assign PCH_LOAD   = act & (state == T6);
  assign P_SET_I    = act & (state == T5);
  assign P_BREAK    = act & (state == T4) & brk_flag;
endmodule

// File: tb/tb_int_seq.sv
// tb_int_seq: directed self-checking bench for int_seq
module tb_int_seq;
  logic CLK = 1'b0, RES, SYNC, BRK_REQ, NMI_N, IRQ_N, I_FLAG;
  logic BUSY, DONE, WR, S_DEC, PCL_LOAD, PCH_LOAD, P_SET_I, P_BREAK;
  logic [1:0] SRC, AB_SEL;
  logic [2:0] DB_OUT_SRC;
  logic [7:0] VEC_LO;
  logic [22:0] o;
  int total = 0, bad = 0;
  int_seq dut (
    .CLK(CLK), .RES(RES), .SYNC(SYNC), .BRK_REQ(BRK_REQ), .NMI_N(NMI_N),
    .IRQ_N(IRQ_N), .I_FLAG(I_FLAG), .BUSY(BUSY), .DONE(DONE), .SRC(SRC),
    .WR(WR), .DB_OUT_SRC(DB_OUT_SRC), .AB_SEL(AB_SEL), .VEC_LO(VEC_LO),
    .S_DEC(S_DEC), .PCL_LOAD(PCL_LOAD), .PCH_LOAD(PCH_LOAD),
    .P_SET_I(P_SET_I), .P_BREAK(P_BREAK)
  );
  always #5 CLK = ~CLK;
  assign o = {BUSY, DONE, SRC, WR, DB_OUT_SRC, AB_SEL, VEC_LO, S_DEC, PCL_LOAD, PCH_LOAD, P_SET_I, P_BREAK};
  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic run_seq(input string tag, input logic [1:0] s, input logic [1:0] s5,
                         input logic w, input logic pb, input logic [7:0] v, input int nmi_at);
    logic [22:0] e [6];
    e[0] = {2'b10, s,  1'b0, 3'd0, 2'd0, 8'd0, 5'b00000};
    e[1] = {2'b10, s,  w,    3'd6, 2'd1, 8'd0, 5'b10000};
    e[2] = {2'b10, s,  w,    3'd5, 2'd1, 8'd0, 5'b10000};
    e[3] = {2'b10, s,  w,    3'd4, 2'd1, 8'd0, 4'b1000, pb};
    e[4] = {2'b10, s5, 1'b0, 3'd0, 2'd2, v,    5'b01010};
    e[5] = {2'b11, s5, 1'b0, 3'd0, 2'd2, v | 8'h01, 5'b00100};
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s_t%0d", tag, k + 1), o, e[k]);
      if (k + 1 == nmi_at) NMI_N = 1'b0;
      step();
    end
    chk($sformatf("%s_idle", tag), o, 23'd0);
  endtask
  initial begin
    RES = 1'b1; SYNC = 1'b0; BRK_REQ = 1'b0; NMI_N = 1'b1; IRQ_N = 1'b1; I_FLAG = 1'b1;
    step(); step();
    chk("in_res", o, {1'b1, 22'd0});
    RES = 1'b0;
    #1 chk("rstw", o, {1'b1, 22'd0});
    step();
    run_seq("rst", 2'd1, 2'd1, 1'b0, 1'b0, 8'hFC, 0);
    IRQ_N = 1'b0; I_FLAG = 1'b0; SYNC = 1'b1;
    step();
    SYNC = 1'b0; IRQ_N = 1'b1;
    run_seq("irq", 2'd3, 2'd3, 1'b1, 1'b0, 8'hFE, 0);
    IRQ_N = 1'b0; I_FLAG = 1'b1; SYNC = 1'b1;
    step();
    chk("irq_masked", o, 23'd0);
    BRK_REQ = 1'b1;
    step();
    SYNC = 1'b0; BRK_REQ = 1'b0; IRQ_N = 1'b1;
    run_seq("brk", 2'd3, 2'd3, 1'b1, 1'b1, 8'hFE, 0);
    NMI_N = 1'b0; IRQ_N = 1'b0; I_FLAG = 1'b0; SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    run_seq("nmi", 2'd2, 2'd2, 1'b1, 1'b0, 8'hFA, 0);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0; IRQ_N = 1'b1; NMI_N = 1'b1;
    run_seq("irq2", 2'd3, 2'd3, 1'b1, 1'b0, 8'hFE, 0);
    SYNC = 1'b1; BRK_REQ = 1'b1;
    step();
    SYNC = 1'b0; BRK_REQ = 1'b0;
    run_seq("hij", 2'd3, 2'd2, 1'b1, 1'b1, 8'hFA, 2);
    NMI_N = 1'b1; SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    chk("nmi_cleared", o, 23'd0);
    IRQ_N = 1'b0; SYNC = 1'b1;
    step();
    SYNC = 1'b0; IRQ_N = 1'b1;
    step(); step();
    chk("pre_res_t3", o, {2'b10, 2'd3, 1'b1, 3'd5, 2'd1, 8'd0, 5'b10000});
    RES = 1'b1;
    #1 chk("res_mid", o, {1'b1, 22'd0});
    step();
    chk("res_held", o, {1'b1, 22'd0});
    RES = 1'b0;
    #1 chk("rstw2", o, {1'b1, 22'd0});
    step();
    run_seq("rst2", 2'd1, 2'd1, 1'b0, 1'b0, 8'hFC, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
